soc_system_pio_data_in: RTL and testbench

Avalon-MM slave input PIO carrying data in the FPGA-fabric-to-HPS direction; the counterpart of the data-out PIO. Fabric logic drives in_port. The block synchronises it, detects edges per bit and latches them in an edge-capture register. When enabled, it raises an interrupt to the HPS. The HPS reads the synchronised level and capture bits over the lightweight bridge and clears captures with write-1-to-clear.

---
 rtl/soc_system_pio_pkg.sv | 19 +
 rtl/soc_system_pio_sync.sv | 32 +++
 rtl/soc_system_pio_data_in.sv | 99 +++++++++
 tb/tb_soc_system_pio_data_in.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS-facing PIO blocks: register map and
// edge-detection encodings.
package soc_system_pio_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge-capture selection
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Bus data width of the lightweight bridge
  localparam int BUS_W = 32;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Multi-stage flip-flop synchroniser for a bus of independent asynchronous
// bits. Each bit is synchronised on its own; no coherency across bits.
module soc_system_pio_sync #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  // Shift the raw input down the chain; the last stage is the clean sample
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= RESET_VALUE;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_pio_data_in.sv
// Avalon-MM input PIO (fabric -> HPS): synchronised level read-back,
// per-bit sticky edge capture with write-1-to-clear, masked level interrupt.
module soc_system_pio_data_in
  import soc_system_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = EDGE_RISING,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic             w_write;
  logic             w_unused_wdata;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic             r_irq;

  soc_system_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RST_V)
  ) u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (in_port),
    .o_q     (w_sync_q)
  );

  // Only the low WIDTH bits of a write carry meaning
  assign w_unused_wdata = ^writedata;

  assign w_write = chipselect & ~write_n;
  assign w_clear = (w_write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // Edge flavour is fixed at elaboration
  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign w_edge = ~w_sync_q & r_prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign w_edge = w_sync_q ^ r_prev;
    end else begin : g_rise
      assign w_edge = w_sync_q & ~r_prev;
    end
  endgenerate

  // Previous synchronised sample for edge comparison
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= RST_V;
    else       r_prev <= w_sync_q;
  end

  // Interrupt mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 r_irq_mask <= '0;
    else if (w_write && address == ADDR_MASK)  r_irq_mask <= writedata[WIDTH-1:0];
  end

  // Sticky captures; a fresh edge overrides a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_edge_capture <= '0;
    else       r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge;
  end

  // Registered level interrupt from any enabled pending capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= |(r_edge_capture & r_irq_mask);
  end

  assign irq = r_irq;

  // Zero-latency read mux, not qualified by chipselect
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = w_sync_q;
      ADDR_MASK: readdata[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = r_edge_capture;
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_pio_data_in.sv
// Bench for the input PIO: a rising-edge and an any-edge instance share all
// inputs and are compared against a sample-history reference model.
module tb_soc_system_pio_data_in;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [W-1:0] in_port = '0;
  logic [31:0]  rd_r, rd_a;
  logic         irq_r, irq_a;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: hist[0] is the newest in_port sample taken at a clock edge
  logic [W-1:0] hist [$];
  logic [W-1:0] m_mask, m_cap_r, m_cap_a;
  logic         m_irq_r, m_irq_a;

  always #5 clk = ~clk;

  soc_system_pio_data_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .RESET_VALUE(32'h0)) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_r),
    .in_port(in_port), .irq(irq_r)
  );

  soc_system_pio_data_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2), .RESET_VALUE(32'h0)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_port), .irq(irq_a)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i <= S; i++) hist.push_back('0);
    m_mask = '0; m_cap_r = '0; m_cap_a = '0; m_irq_r = 1'b0; m_irq_a = 1'b0;
  endtask

  // One clock edge; the model consumes the inputs present at that edge
  task automatic tick();
    logic [W-1:0] s_old, p_old, clr;
    @(posedge clk);
    if (!reset) begin
      s_old = hist[S-1];
      p_old = hist[S];
      m_irq_r = |(m_cap_r & m_mask);
      m_irq_a = |(m_cap_a & m_mask);
      clr = '0;
      if (chipselect && !write_n && address == 2'd3) clr = writedata[W-1:0];
      m_cap_r = (m_cap_r & ~clr) | (s_old & ~p_old);
      m_cap_a = (m_cap_a & ~clr) | (s_old ^ p_old);
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      hist.push_front(in_port);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  function automatic logic [31:0] exp_rd(input int a, input bit any_dut);
    logic [31:0] v;
    v = '0;
    case (a)
      0: v[W-1:0] = hist[S-1];
      2: v[W-1:0] = m_mask;
      3: v[W-1:0] = any_dut ? m_cap_a : m_cap_r;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Read every address plus irq on both instances and compare to the model
  task automatic check_all(input string tag);
    for (int a = 0; a < 4; a++) begin
      address = a[1:0];
      #1;
      chk($sformatf("%s_rise_a%0d", tag, a), rd_r, exp_rd(a, 1'b0));
      chk($sformatf("%s_any_a%0d", tag, a), rd_a, exp_rd(a, 1'b1));
    end
    chk({tag, "_rise_irq"}, {31'b0, irq_r}, {31'b0, m_irq_r});
    chk({tag, "_any_irq"},  {31'b0, irq_a}, {31'b0, m_irq_a});
  endtask

  initial begin
    // 1: reset state
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_all("reset");
    address = 2'd0; #1; chk("reset_data_const", rd_r, 32'h0);

    // 2: rising edges on bits 0 and 2, mask still 0
    in_port = 8'h05;
    repeat (S + 1) tick();
    check_all("edge05");
    address = 2'd3; #1; chk("edge05_cap_const", rd_r, 32'h05);
    address = 2'd0; #1; chk("edge05_data_const", rd_r, 32'h05);
    chk("edge05_irq_const", {31'b0, irq_r}, 32'h0);

    // 3: enable mask bit 2, then clear capture bit 2
    bus_write(2'd2, 32'h04);
    check_all("mask_wr");
    tick();
    chk("mask_irq_const", {31'b0, irq_r}, 32'h1);
    check_all("mask_irq");
    bus_write(2'd3, 32'h04);
    address = 2'd3; #1; chk("clr_cap_const", rd_r, 32'h01);
    tick();
    chk("clr_irq_const", {31'b0, irq_r}, 32'h0);
    check_all("clr");

    // 4: rising edge on bit 1 coincides with a clear of bit 1
    in_port = 8'h07;
    repeat (S) tick();
    bus_write(2'd3, 32'h02);
    address = 2'd3; #1; chk("setwins_const", rd_r & 32'h2, 32'h2);
    check_all("setwins");

    // 5: bit 7 falling edge only seen by the any-edge instance; data write ignored
    bus_write(2'd3, 32'hFF);
    in_port = 8'h87;
    repeat (S + 2) tick();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h07;
    repeat (S + 2) tick();
    address = 2'd3; #1;
    chk("fall7_any_const", rd_a & 32'h80, 32'h80);
    chk("fall7_rise_const", rd_r & 32'h80, 32'h00);
    bus_write(2'd0, 32'hFF);
    bus_write(2'd1, 32'hFF);
    check_all("addr0_wr");

    // Randomised traffic: input toggles, writes, deselected strobes
    for (int n = 0; n < 300; n++) begin
      in_port    = W'($urandom);
      chipselect = 1'($urandom);
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom);
      writedata  = $urandom;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
      check_all($sformatf("rnd%0d", n));
    end

    // 6: reset mid-cycle with irq pending; no clock needed
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'hFF);
    in_port = 8'h00;
    repeat (S + 2) tick();
    in_port = 8'hFF;
    repeat (S + 2) tick();
    chk("pre_reset_irq", {31'b0, irq_r}, 32'h1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_irq_rise", {31'b0, irq_r}, 32'h0);
    chk("async_irq_any",  {31'b0, irq_a}, 32'h0);
    address = 2'd2; #1; chk("async_mask", rd_r, 32'h0);
    address = 2'd3; #1; chk("async_cap", rd_a, 32'h0);
    address = 2'd0; #1; chk("async_data", rd_r, 32'h0);
    tick();
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
